// File: rtl/gmm_structures.sv
// Shared types for the GMM background-subtract frame control.
// Holds the frame FSM encoding and the default pixel-counter width.
package gmm_structures;

    localparam int PIX_W_DEF = 22;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/gmm_subtract_frame_ctrl.sv
// Frame sequencer for the GMM subtract pipeline: latches a per-frame
// threshold, gates the upstream handshake and counts beats in and out.
module gmm_subtract_frame_ctrl
    import gmm_structures::*;
#(
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [7:0]       cfg_bg_th,
    input  logic [PIX_W-1:0] cfg_pixels,
    input  logic             up_valid,
    output logic             up_ready,
    output logic             pipe_snk_valid,
    input  logic             pipe_snk_ready,
    input  logic             pipe_out_valid,
    input  logic             pipe_out_ready,
    output logic [7:0]       bg_th,
    output logic             busy,
    output logic             frame_done,
    output logic             start_ignored
);

    localparam logic [PIX_W-1:0] ONE = PIX_W'(1);

    state_e           state_q, state_d;
    logic [7:0]       bg_th_q, bg_th_d;
    logic [PIX_W-1:0] len_q, len_d;
    logic [PIX_W-1:0] in_cnt_q, in_cnt_d;
    logic [PIX_W-1:0] out_cnt_q, out_cnt_d;
    logic             ign_q, ign_d;

    logic in_open;
    logic in_fire;
    logic out_fire;
    logic in_last;
    logic out_last;
    logic accept;

    assign in_open        = (state_q == ST_RUN) && (in_cnt_q < len_q);
    assign pipe_snk_valid = in_open & up_valid;
    assign up_ready       = in_open & pipe_snk_ready;
    assign in_fire        = up_valid & up_ready;
    assign accept         = (state_q == ST_IDLE) && cfg_start
                            && (cfg_pixels != '0);

    // Tail beats may not run ahead of head beats, even in the same cycle.
    always_comb begin
        in_cnt_d = in_fire ? in_cnt_q + ONE : in_cnt_q;
        out_fire = pipe_out_valid & pipe_out_ready
                   & ((state_q == ST_RUN) || (state_q == ST_DRAIN))
                   & (out_cnt_q < in_cnt_d);
        in_last  = in_fire && ((in_cnt_q + ONE) == len_q);
        out_last = out_fire && ((out_cnt_q + ONE) == len_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_RUN;
            ST_RUN: begin
                if (in_last && out_last) state_d = ST_DONE;
                else if (in_last)        state_d = ST_DRAIN;
            end
            ST_DRAIN: if (out_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != ST_IDLE);
        frame_done = (state_q == ST_DONE);
    end

    always_comb begin
        bg_th_d   = bg_th_q;
        len_d     = len_q;
        out_cnt_d = out_fire ? out_cnt_q + ONE : out_cnt_q;
        ign_d     = ign_q | (cfg_start & (state_q != ST_IDLE));
        if (accept) begin
            bg_th_d   = cfg_bg_th;
            len_d     = cfg_pixels;
            out_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bg_th_q   <= '0;
            len_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            ign_q     <= 1'b0;
        end else begin
            bg_th_q   <= bg_th_d;
            len_q     <= len_d;
            in_cnt_q  <= accept ? '0 : in_cnt_d;
            out_cnt_q <= out_cnt_d;
            ign_q     <= ign_d;
        end
    end

    assign bg_th         = bg_th_q;
    assign start_ignored = ign_q;

endmodule

// File: tb/tb_gmm_subtract_frame_ctrl.sv
// Bench for gmm_subtract_frame_ctrl with a modelled fixed-latency pipe.
// Head beats push the frame threshold; tail beats pop and compare it.
module tb_gmm_subtract_frame_ctrl;

    localparam int PIX_W = 22;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_start;
    logic [7:0]       cfg_bg_th;
    logic [PIX_W-1:0] cfg_pixels;
    logic             up_valid;
    logic             up_ready;
    logic             pipe_snk_valid;
    logic             pipe_snk_ready;
    logic             pipe_out_valid;
    logic             pipe_out_ready;
    logic [7:0]       bg_th;
    logic             busy;
    logic             frame_done;
    logic             start_ignored;

    gmm_subtract_frame_ctrl #(.PIX_W(PIX_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_start      (cfg_start),
        .cfg_bg_th      (cfg_bg_th),
        .cfg_pixels     (cfg_pixels),
        .up_valid       (up_valid),
        .up_ready       (up_ready),
        .pipe_snk_valid (pipe_snk_valid),
        .pipe_snk_ready (pipe_snk_ready),
        .pipe_out_valid (pipe_out_valid),
        .pipe_out_ready (pipe_out_ready),
        .bg_th          (bg_th),
        .busy           (busy),
        .frame_done     (frame_done),
        .start_ignored  (start_ignored)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int lat;
    logic [7:0] sh;
    logic [7:0] sbq[$];
    logic [7:0] exp_th;
    int nin, nout, ndone, cyc, last_in_cyc, done_cyc, cur_len, rdy_viol;

    task automatic clear_model();
        sbq.delete();
        sh = '0;
        nin = 0;
        nout = 0;
        ndone = 0;
        rdy_viol = 0;
        last_in_cyc = -1;
        done_cyc = -1;
    endtask

    // One clock: model head/tail of the pipe, score tail beats, advance.
    task automatic tick();
        bit head, tail;
        logic [7:0] e;
        #1;
        if (up_ready && nin >= cur_len) rdy_viol++;
        head = pipe_snk_valid & pipe_snk_ready;
        if (head) begin
            sbq.push_back(exp_th);
            nin++;
            last_in_cyc = cyc;
        end
        pipe_out_valid = (lat == 0) ? head : sh[lat-1];
        #1;
        tail = pipe_out_valid & pipe_out_ready & busy & !frame_done;
        if (tail) begin
            nout++;
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow got=tail_beat exp=none");
            end else begin
                e = sbq.pop_front();
                if (bg_th !== e) begin
                    bad++;
                    $display("FAIL sb_bg_th got=%h exp=%h", bg_th, e);
                end
            end
        end
        if (frame_done) begin
            ndone++;
            done_cyc = cyc;
        end
        sh = {sh[6:0], head};
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_frame(input int pix, input logic [7:0] th);
        cfg_start  = 1'b1;
        cfg_pixels = PIX_W'(pix);
        cfg_bg_th  = th;
        exp_th     = th;
        cur_len    = pix;
        tick();
        cfg_start  = 1'b0;
    endtask

    task automatic run_frame(input int maxc, output bit ok);
        for (int i = 0; i < maxc && ndone == 0; i++) tick();
        ok = (ndone != 0);
    endtask

    task automatic test_reset();
        bit [5:0] o;
        rst = 1'b1;
        pipe_snk_ready = 1'b1;
        up_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        o = {busy, frame_done, start_ignored, up_ready,
             pipe_snk_valid, |bg_th};
        total++;
        if (o !== 6'b0) begin
            bad++;
            $display("FAIL reset_outs got=%b exp=000000", o);
        end
        rst = 1'b0;
        up_valid = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got=%b exp=0", busy);
        end
    endtask

    task automatic test_zero_len();
        clear_model();
        cfg_start = 1'b1;
        cfg_pixels = '0;
        cfg_bg_th = 8'h77;
        tick();
        cfg_start = 1'b0;
        total++;
        if ({busy, start_ignored, bg_th} !== {2'b00, 8'h00}) begin
            bad++;
            $display("FAIL zero_len got=%b%b/%h exp=00/00",
                     busy, start_ignored, bg_th);
        end
    endtask

    task automatic test_basic();
        bit ok;
        clear_model();
        lat = 2;
        start_frame(4, 8'hB4);
        total++;
        if (busy !== 1'b1 || bg_th !== 8'hB4) begin
            bad++;
            $display("FAIL basic_start got=%b/%h exp=1/b4", busy, bg_th);
        end
        up_valid = 1'b1;
        run_frame(30, ok);
        up_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL basic_timeout got=no_done exp=done");
        end
        total++;
        if (nin !== 4 || nout !== 4) begin
            bad++;
            $display("FAIL basic_beats got=%0d/%0d exp=4/4", nin, nout);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle got=%b exp=0", busy);
        end
        repeat (3) tick();
        total++;
        if (ndone !== 1) begin
            bad++;
            $display("FAIL basic_done_cnt got=%0d exp=1", ndone);
        end
    endtask

    task automatic test_th_change();
        bit ok;
        clear_model();
        lat = 2;
        start_frame(5, 8'hB4);
        up_valid = 1'b1;
        tick();
        cfg_bg_th = 8'h10;
        tick();
        total++;
        if (bg_th !== 8'hB4) begin
            bad++;
            $display("FAIL th_mid got=%h exp=b4", bg_th);
        end
        run_frame(30, ok);
        total++;
        if (!ok || bg_th !== 8'hB4) begin
            bad++;
            $display("FAIL th_end got=%0d/%h exp=1/b4", ok, bg_th);
        end
        clear_model();
        up_valid = 1'b0;
        start_frame(2, 8'h10);
        total++;
        if (bg_th !== 8'h10) begin
            bad++;
            $display("FAIL th_next got=%h exp=10", bg_th);
        end
        up_valid = 1'b1;
        run_frame(30, ok);
        up_valid = 1'b0;
        total++;
        if (!ok || nout !== 2) begin
            bad++;
            $display("FAIL th_next_frame got=%0d/%0d exp=1/2", ok, nout);
        end
    endtask

    task automatic test_backpressure();
        clear_model();
        lat = 2;
        start_frame(8, 8'h5A);
        up_valid = 1'b1;
        for (int i = 0; i < 80 && ndone == 0; i++) begin
            pipe_snk_ready = i[0];
            tick();
        end
        up_valid = 1'b0;
        pipe_snk_ready = 1'b1;
        total++;
        if (nin !== 8 || nout !== 8 || ndone !== 1) begin
            bad++;
            $display("FAIL bp_beats got=%0d/%0d/%0d exp=8/8/1",
                     nin, nout, ndone);
        end
        total++;
        if (rdy_viol !== 0) begin
            bad++;
            $display("FAIL bp_ready_after_len got=%0d exp=0", rdy_viol);
        end
    endtask

    task automatic test_simul_last();
        bit ok;
        clear_model();
        lat = 0;
        start_frame(3, 8'h33);
        up_valid = 1'b1;
        run_frame(20, ok);
        up_valid = 1'b0;
        total++;
        if (!ok || nout !== 3) begin
            bad++;
            $display("FAIL simul_frame got=%0d/%0d exp=1/3", ok, nout);
        end
        total++;
        if (done_cyc - last_in_cyc !== 1) begin
            bad++;
            $display("FAIL simul_gap got=%0d exp=1",
                     done_cyc - last_in_cyc);
        end
        repeat (2) tick();
        total++;
        if (ndone !== 1) begin
            bad++;
            $display("FAIL simul_done_cnt got=%0d exp=1", ndone);
        end
    endtask

    task automatic test_start_busy();
        bit ok;
        clear_model();
        lat = 3;
        start_frame(4, 8'h44);
        up_valid = 1'b1;
        for (int i = 0; i < 20 && nin < 4; i++) tick();
        total++;
        if (busy !== 1'b1 || up_ready !== 1'b0 || start_ignored !== 1'b0) begin
            bad++;
            $display("FAIL sb_drain got=%b%b%b exp=100",
                     busy, up_ready, start_ignored);
        end
        cfg_start = 1'b1;
        cfg_pixels = PIX_W'(5);
        cfg_bg_th = 8'h99;
        tick();
        cfg_start = 1'b0;
        total++;
        if (start_ignored !== 1'b1) begin
            bad++;
            $display("FAIL sb_flag got=%b exp=1", start_ignored);
        end
        run_frame(30, ok);
        repeat (5) tick();
        up_valid = 1'b0;
        total++;
        if (!ok || nin !== 4 || nout !== 4 || ndone !== 1) begin
            bad++;
            $display("FAIL sb_finish got=%0d/%0d/%0d/%0d exp=1/4/4/1",
                     ok, nin, nout, ndone);
        end
        total++;
        if (busy !== 1'b0 || bg_th !== 8'h44 || start_ignored !== 1'b1) begin
            bad++;
            $display("FAIL sb_no_new got=%b/%h/%b exp=0/44/1",
                     busy, bg_th, start_ignored);
        end
    endtask

    task automatic test_reset_drain();
        bit [5:0] o;
        clear_model();
        lat = 3;
        start_frame(6, 8'h66);
        up_valid = 1'b1;
        for (int i = 0; i < 20 && nin < 6; i++) tick();
        total++;
        if (nin !== 6 || nout !== 3 || busy !== 1'b1) begin
            bad++;
            $display("FAIL rd_pre got=%0d/%0d/%b exp=6/3/1", nin, nout, busy);
        end
        rst = 1'b1;
        #1;
        o = {busy, frame_done, start_ignored, up_ready,
             pipe_snk_valid, |bg_th};
        total++;
        if (o !== 6'b0) begin
            bad++;
            $display("FAIL rd_outs got=%b exp=000000", o);
        end
        clear_model();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        total++;
        if (ndone !== 0 || busy !== 1'b0 || up_ready !== 1'b0) begin
            bad++;
            $display("FAIL rd_after got=%0d/%b/%b exp=0/0/0",
                     ndone, busy, up_ready);
        end
        up_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cfg_start = 1'b0;
        cfg_bg_th = '0;
        cfg_pixels = '0;
        up_valid = 1'b0;
        pipe_snk_ready = 1'b1;
        pipe_out_valid = 1'b0;
        pipe_out_ready = 1'b1;
        lat = 2;
        cyc = 0;
        cur_len = 0;
        exp_th = '0;
        clear_model();
        test_reset();
        test_zero_len();
        test_basic();
        test_th_change();
        test_backpressure();
        test_simul_last();
        test_start_busy();
        test_reset_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
